multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Multicycle sequencer for the MIPS datapath: one shared memory port, one ALU, IR/MDR/A/B/ALUOut regs.
//  Decodes opcode from IR and steps FETCH->DECODE->EXEC->MEM->WB, driving per-cycle datapath enables.
//  Memory accesses use a req/ready handshake with a bounded wait; supports R-type, ADDI, BEQ, J, LW, SW.
// PARAMETERS
//  MEM_WAIT_MAX  16  max cycles a memory state waits for mem_ready before abort (>=1)
//  CNT_W         5   width of wait counter; must hold MEM_WAIT_MAX
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  opcode       in   6  IR[31:26], valid from DECODE onward
//  zero         in   1  ALU zero flag (BEQ)
//  mem_ready    in   1  memory completes current access this cycle
//  mem_read     out  1  memory read request (fetch or LW)
//  mem_write    out  1  memory write request (SW)
//  i_or_d       out  1  0: address=PC, 1: address=ALUOut
//  ir_write     out  1  load IR from memory data
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if zero (BEQ)
//  pc_source    out  2  0: ALU result, 1: ALUOut, 2: jump target
//  alu_src_a    out  1  0: PC, 1: reg A
//  alu_src_b    out  2  0: reg B, 1: const 4, 2: sign-ext imm, 3: sign-ext imm<<2
//  alu_op       out  2  0: add, 1: sub, 2: R-type funct decode
//  reg_dst      out  1  0: rt, 1: rd
//  mem_2_reg    out  1  0: ALUOut, 1: MDR
//  reg_write    out  1  register file write enable
//  instr_done   out  1  1-cycle pulse when an instruction retires
//  illegal_op   out  1  1-cycle pulse in DECODE for unsupported opcode
//  mem_error    out  1  1-cycle pulse on memory wait timeout
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0; every output 0 (alu_op=0, pc_source=0, alu_src_b=0).
//  States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
//  Control outputs are Moore (decoded from state) except qualified enables noted below (Mealy on mem_ready).
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0;
//   ir_write=pc_write=mem_ready; on mem_ready -> DECODE, else stay.
//  DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target to ALUOut). Next by opcode:
//   0x00->R_EXEC, 0x08->I_EXEC, 0x04->BRANCH, 0x02->JUMP, 0x23/0x2B->MEM_ADDR; other -> FETCH + illegal_op.
//  MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0; -> MEM_RD (0x23) or MEM_WR (0x2B).
//  MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> MEM_WB.  MEM_WB: reg_dst=0, mem_2_reg=1, reg_write=1 -> FETCH.
//  MEM_WR: mem_write=1, i_or_d=1; on mem_ready -> FETCH with instr_done.
//  R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2 -> R_WB: reg_dst=1, reg_write=1 -> FETCH.
//  I_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0 -> I_WB: reg_dst=0, reg_write=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1 -> FETCH.
//  JUMP: pc_write=1, pc_source=2 -> FETCH.
//  instr_done pulses in the cycle of every transition into FETCH except from DECODE (illegal) and timeout.
//  Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle mem_ready=0 there.
//   Count reaching MEM_WAIT_MAX with mem_ready=0: mem_error pulse, drop request, -> FETCH, no writes,
//   no ir_write/pc_write. mem_ready in the same cycle as the limit wins (normal completion).
//  mem_read and mem_write never both 1; reg_write and mem_write never both 1.
//  Reset asserted mid-instruction: immediate return to FETCH, in-flight write requests drop same cycle.
//  opcode sampled only in DECODE and MEM_ADDR; changes elsewhere ignored.
// STRUCTURE
//  mips_ctrl_pkg: opcode constants, alu_op codes, pc_source/alu_src_b codes, state encoding (4-bit).
//  Sub-module mem_wait_timer: counter + clear/inc/expired, parameterised MEM_WAIT_MAX, CNT_W.
//  Main FSM: state register + combinational next-state/output decode.
// TESTING
//  R-type (op 0x00), mem_ready=1 in FETCH -> 4 cycles FETCH,DECODE,R_EXEC,R_WB; reg_dst=1, reg_write=1 in R_WB.
//  LW (0x23), mem_ready 3 cycles late in MEM_RD -> 5+3 cycles; mem_2_reg=1, reg_write=1 only in MEM_WB.
//  BEQ (0x04), zero=1 -> pc_write_cond=1, pc_source=1, alu_op=1 in BRANCH; total 3 cycles.
//  opcode 0x3F in DECODE -> illegal_op pulse, next state FETCH, no reg_write/mem_write, no instr_done.
//  SW with mem_ready held 0, MEM_WAIT_MAX=4 -> mem_error after 4 wait cycles, mem_write drops, back to FETCH.
//  rst pulsed during MEM_WR -> mem_write=0 immediately; FETCH after release with all outputs reset values.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer.
// Contents: supported opcodes, ALU operation codes, PC source and ALU B
// operand select codes, and the 4-bit FSM state encoding.
package mips_ctrl_pkg;

  // Supported opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // alu_op codes
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // pc_source codes
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // alu_src_b codes
  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // States that issue a memory request and therefore wait on mem_ready.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait counter for memory accesses.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - zero the counter (takes priority over inc)
//   inc       - count one more cycle without mem_ready
//   expired   - high when the next increment would reach MEM_WAIT_MAX,
//               i.e. the current cycle is the last one the access may wait
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A request waits at most MEM_WAIT_MAX cycles: when the count already
  // holds MEM_WAIT_MAX-1, this cycle's increment reaches the limit.
  assign expired = (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer. Steps FETCH/DECODE/EXEC/MEM/WB and
// drives per-cycle datapath enables for R-type, ADDI, BEQ, J, LW and SW.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   opcode, zero       - IR[31:26] and ALU zero flag
//   mem_ready          - memory completes the current access this cycle
//   mem_read/mem_write - memory requests; i_or_d selects PC or ALUOut address
//   ir_write, pc_write, pc_write_cond, pc_source - IR/PC update controls
//   alu_src_a, alu_src_b, alu_op                - ALU operand/op selects
//   reg_dst, mem_2_reg, reg_write               - register file controls
//   instr_done, illegal_op, mem_error           - single-cycle status pulses
// Handshake: a memory request (mem_read or mem_write) is held every cycle
// the FSM sits in FETCH/MEM_RD/MEM_WR; the access completes in the cycle
// mem_ready is sampled high with the request up. If mem_ready has not been
// seen after MEM_WAIT_MAX cycles the request is dropped, mem_error pulses
// and the sequencer returns to FETCH. mem_ready outside a request is ignored.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_2_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_error
);

  state_t state_q;
  state_t state_d;

  logic in_wait;
  logic timer_inc;
  logic timer_clr;
  logic timer_expired;
  logic timeout;

  // zero is consumed by the datapath (pc_write_cond gating), not here.
  logic unused_zero;
  assign unused_zero = zero;

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    reg_dst       = 1'b0;
    mem_2_reg     = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_error     = 1'b0;

    // Counter runs only while a request is outstanding and unanswered; any
    // completion, timeout or non-memory state leaves it at zero, so every
    // entry into a memory state starts a fresh wait window.
    in_wait   = is_mem_wait_state(state_q);
    timer_inc = in_wait && !mem_ready;
    timeout   = timer_inc && timer_expired;
    timer_clr = !in_wait || mem_ready || timeout;

    // Outputs held at zero while reset is asserted so in-flight requests
    // drop in the same cycle, not at the next clock edge.
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) begin
            state_d = S_DECODE;
          end else if (timeout) begin
            mem_error = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          unique case (opcode)
            OP_RTYPE:    state_d = S_R_EXEC;
            OP_ADDI:     state_d = S_I_EXEC;
            OP_BEQ:      state_d = S_BRANCH;
            OP_J:        state_d = S_JUMP;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            state_d = S_MEM_WB;
          end else if (timeout) begin
            mem_error = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_MEM_WB: begin
          mem_2_reg  = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (timeout) begin
            mem_error = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = S_I_WB;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PC_SRC_ALUOUT;
          instr_done    = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PC_SRC_JUMP;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule
